// File: rtl/wbpi_rrarb_pkg.sv
// Shared types and constants for the wbpi_rrarb round-robin bus arbiter.
package wbpi_rrarb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_ABORT = 2'd2
  } state_e;

  localparam int OUTST_W = 4;
  localparam logic [OUTST_W-1:0] OUTST_MAX = 4'd15;

  // Outstanding-transaction count update; a same-cycle inc and dec cancel.
  function automatic logic [OUTST_W-1:0] outst_next(input logic [OUTST_W-1:0] cur,
                                                    input logic inc,
                                                    input logic dec);
    logic [OUTST_W-1:0] nxt;
    nxt = cur;
    if (inc && !dec) nxt = cur + 1'b1;
    if (dec && !inc) nxt = cur - 1'b1;
    return nxt;
  endfunction

endpackage

// File: rtl/wbpi_rrarb_rr_pick.sv
// Rotating first-set pick: one-hot grant to the first request at or after ptr_i.
module wbpi_rrarb_rr_pick
  import wbpi_rrarb_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);

  always_comb begin
    logic          found;
    logic [IW-1:0] idx;
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = IW'((32'(ptr_i) + 32'(k)) % 32'(N));
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wbpi_rrarb.sv
// Round-robin arbiter from MASTERCOUNT pipelined bus masters onto one slave port.
// Optional watchdog abort is built when WBPI_RRARB_TIMEOUT_EN is defined.
module wbpi_rrarb
  import wbpi_rrarb_pkg::*;
#(
  parameter int MASTERCOUNT = 2,
  parameter int ARCHBITSZ   = 32,
  parameter int ADDRBITSZ   = 30,
  parameter int TIMEOUT     = 1024
) (
  input  logic                               clk_2x_w,
  input  logic                               rst_n,
  input  logic [MASTERCOUNT-1:0]             m_cyc_i,
  input  logic [MASTERCOUNT-1:0]             m_stb_i,
  input  logic [MASTERCOUNT-1:0]             m_we_i,
  input  logic [MASTERCOUNT*ADDRBITSZ-1:0]   m_addr_i,
  input  logic [MASTERCOUNT*ARCHBITSZ/8-1:0] m_sel_i,
  input  logic [MASTERCOUNT*ARCHBITSZ-1:0]   m_dat_i,
  output logic [MASTERCOUNT-1:0]             m_bsy_o,
  output logic [MASTERCOUNT-1:0]             m_ack_o,
  output logic [ARCHBITSZ-1:0]               m_dat_o,
  output logic                               s_cyc_o,
  output logic                               s_stb_o,
  output logic                               s_we_o,
  output logic [ADDRBITSZ-1:0]               s_addr_o,
  output logic [ARCHBITSZ/8-1:0]             s_sel_o,
  output logic [ARCHBITSZ-1:0]               s_dat_o,
  input  logic                               s_bsy_i,
  input  logic                               s_ack_i,
  input  logic [ARCHBITSZ-1:0]               s_dat_i,
  output logic [MASTERCOUNT-1:0]             gnt_o,
  output logic                               tmo_o
);

  localparam int IW = $clog2(MASTERCOUNT);
  localparam int SW = ARCHBITSZ / 8;

  if (MASTERCOUNT < 2 || MASTERCOUNT > 8 || TIMEOUT < 1) begin : g_bad_cfg
    $error("wbpi_rrarb: unsupported parameter set");
  end

  state_e                 state_q, state_d;
  logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [MASTERCOUNT-1:0] gnt_q, gnt_d;
  logic [OUTST_W-1:0]     outst_q, outst_d;
  logic [MASTERCOUNT-1:0] pick;
  logic [IW-1:0]          own_idx;
  logic [IW-1:0]          nxt_ptr;
  logic                   full;
  logic                   stb_fwd;

`ifdef WBPI_RRARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wdog_q, wdog_d;
`endif

  wbpi_rrarb_rr_pick #(.N(MASTERCOUNT), .IW(IW)) u_rr_pick (
    .req_i (m_cyc_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick)
  );

  always_comb begin
    own_idx = '0;
    for (int i = 0; i < MASTERCOUNT; i++) begin
      if (gnt_q[i]) own_idx = IW'(i);
    end
  end

  assign nxt_ptr = (own_idx == IW'(MASTERCOUNT - 1)) ? '0 : own_idx + 1'b1;
  assign full    = (outst_q == OUTST_MAX);
  assign gnt_o   = gnt_q;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gnt_d    = gnt_q;
    outst_d  = outst_q;
    stb_fwd  = 1'b0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_addr_o = '0;
    s_sel_o  = '0;
    s_dat_o  = '0;
    m_bsy_o  = m_cyc_i;
    m_ack_o  = '0;
    m_dat_o  = s_dat_i;
`ifdef WBPI_RRARB_TIMEOUT_EN
    wdog_d   = '0;
    tmo_o    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|m_cyc_i) begin
          gnt_d   = pick;
          state_d = ST_OWN;
        end
      end
      ST_OWN: begin
        stb_fwd           = m_stb_i[own_idx] & ~full;
        s_cyc_o           = m_cyc_i[own_idx];
        s_stb_o           = stb_fwd;
        s_we_o            = m_we_i[own_idx];
        s_addr_o          = m_addr_i[int'(own_idx)*ADDRBITSZ +: ADDRBITSZ];
        s_sel_o           = m_sel_i[int'(own_idx)*SW +: SW];
        s_dat_o           = m_dat_i[int'(own_idx)*ARCHBITSZ +: ARCHBITSZ];
        m_bsy_o[own_idx]  = s_bsy_i | full;
        m_ack_o[own_idx]  = s_ack_i;
        // Acks with nothing outstanding are dropped so the count cannot wrap.
        outst_d = outst_next(outst_q, stb_fwd & ~s_bsy_i, s_ack_i & (outst_q != '0));
`ifdef WBPI_RRARB_TIMEOUT_EN
        wdog_d = s_ack_i ? '0 : wdog_q + 1'b1;
`endif
        if (!m_cyc_i[own_idx] && outst_q == '0) begin
          state_d  = ST_IDLE;
          gnt_d    = '0;
          rr_ptr_d = nxt_ptr;
`ifdef WBPI_RRARB_TIMEOUT_EN
          wdog_d   = '0;
        end else if (!s_ack_i && (wdog_q + 1'b1) == WD_W'(TIMEOUT)) begin
          state_d  = ST_ABORT;
`endif
        end
      end
`ifdef WBPI_RRARB_TIMEOUT_EN
      ST_ABORT: begin
        tmo_o            = 1'b1;
        m_bsy_o[own_idx] = 1'b0;
        m_ack_o[own_idx] = 1'b1;
        m_dat_o          = '1;
        outst_d          = '0;
        state_d          = ST_IDLE;
        gnt_d            = '0;
        rr_ptr_d         = nxt_ptr;
      end
`endif
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        outst_d = '0;
      end
    endcase
  end

`ifndef WBPI_RRARB_TIMEOUT_EN
  assign tmo_o = 1'b0;
`endif

  always_ff @(posedge clk_2x_w) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      outst_q  <= '0;
`ifdef WBPI_RRARB_TIMEOUT_EN
      wdog_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      outst_q  <= outst_d;
`ifdef WBPI_RRARB_TIMEOUT_EN
      wdog_q   <= wdog_d;
`endif
    end
  end

endmodule

// File: tb/tb_wbpi_rrarb.sv
// Directed self-checking bench for wbpi_rrarb (2 masters, 32-bit data, TIMEOUT=16).
module tb_wbpi_rrarb;

  logic        clk_2x_w = 1'b0;
  logic        rst_n;
  logic [1:0]  m_cyc, m_stb, m_we;
  logic [59:0] m_addr;
  logic [7:0]  m_sel;
  logic [63:0] m_dat;
  logic [1:0]  m_bsy_o, m_ack_o;
  logic [31:0] m_dat_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [29:0] s_addr_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_dat_o;
  logic        s_bsy, s_ack;
  logic [31:0] s_dat;
  logic [1:0]  gnt_o;
  logic        tmo_o;

  int checks = 0;
  int errors = 0;

  wbpi_rrarb #(
    .MASTERCOUNT(2), .ARCHBITSZ(32), .ADDRBITSZ(30), .TIMEOUT(16)
  ) dut (
    .clk_2x_w (clk_2x_w),
    .rst_n    (rst_n),
    .m_cyc_i  (m_cyc),
    .m_stb_i  (m_stb),
    .m_we_i   (m_we),
    .m_addr_i (m_addr),
    .m_sel_i  (m_sel),
    .m_dat_i  (m_dat),
    .m_bsy_o  (m_bsy_o),
    .m_ack_o  (m_ack_o),
    .m_dat_o  (m_dat_o),
    .s_cyc_o  (s_cyc_o),
    .s_stb_o  (s_stb_o),
    .s_we_o   (s_we_o),
    .s_addr_o (s_addr_o),
    .s_sel_o  (s_sel_o),
    .s_dat_o  (s_dat_o),
    .s_bsy_i  (s_bsy),
    .s_ack_i  (s_ack),
    .s_dat_i  (s_dat),
    .gnt_o    (gnt_o),
    .tmo_o    (tmo_o)
  );

  always #5 clk_2x_w = ~clk_2x_w;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_2x_w);
    #1;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    m_cyc  = '0;
    m_stb  = '0;
    m_we   = '0;
    m_addr = '0;
    m_sel  = '0;
    m_dat  = '0;
    s_bsy  = 1'b0;
    s_ack  = 1'b0;
    s_dat  = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Master m's strobe is being accepted this cycle: ack it next cycle, then drop cyc.
  task automatic finish_txn(input int m);
    logic [1:0] exp;
    exp = 2'b01 << m;
    tick();
    m_stb[m] = 1'b0;
    s_ack    = 1'b1;
    #1;
    chk("txn_ack", m_ack_o, exp);
    tick();
    s_ack    = 1'b0;
    m_cyc[m] = 1'b0;
    tick();
    chk("txn_release", gnt_o, 2'b00);
  endtask

  initial begin
    int n;

    // Reset state
    do_reset();
    chk("rst_gnt", gnt_o, 2'b00);
    chk("rst_tmo", tmo_o, 1'b0);
    chk("rst_scyc", s_cyc_o, 1'b0);

    // Single master read, ack two cycles after the strobe
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_addr[29:0] = 30'h400; m_sel[3:0] = 4'hF;
    #1;
    chk("idle_sstb", s_stb_o, 1'b0);
    chk("idle_bsy", m_bsy_o, 2'b01);
    chk("idle_gnt", gnt_o, 2'b00);
    tick();
    chk("rd_gnt", gnt_o, 2'b01);
    chk("rd_addr", s_addr_o, 30'h400);
    chk("rd_stb", s_stb_o, 1'b1);
    chk("rd_bsy", m_bsy_o, 2'b00);
    tick();
    m_stb[0] = 1'b0;
    tick();
    s_ack = 1'b1; s_dat = 32'hCAFE_F00D;
    #1;
    chk("rd_ack", m_ack_o, 2'b01);
    chk("rd_dat", m_dat_o, 32'hCAFE_F00D);
    tick();
    s_ack = 1'b0; m_cyc[0] = 1'b0;
    #1;
    chk("rd_hold", gnt_o, 2'b01);
    tick();
    chk("rd_idle_gnt", gnt_o, 2'b00);
    chk("rd_idle_cyc", s_cyc_o, 1'b0);

    // Tie from reset, then rotation, then the next tie returns to master 0
    do_reset();
    m_cyc = 2'b11; m_stb = 2'b11;
    m_addr[29:0] = 30'h111; m_addr[59:30] = 30'h222;
    tick();
    chk("tie_gnt0", gnt_o, 2'b01);
    chk("tie_addr0", s_addr_o, 30'h111);
    chk("tie_bsy", m_bsy_o, 2'b10);
    finish_txn(0);
    tick();
    chk("tie_gnt1", gnt_o, 2'b10);
    chk("tie_addr1", s_addr_o, 30'h222);
    finish_txn(1);
    m_cyc = 2'b11; m_stb = 2'b11;
    tick();
    chk("tie_again", gnt_o, 2'b01);

    // 16 back-to-back strobes with no ack
    do_reset();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    tick();
    n = 0;
    for (int i = 0; i < 15; i++) begin
      if (s_stb_o && !s_bsy) n++;
      tick();
    end
    chk("full_accepted", n, 15);
    chk("full_bsy", m_bsy_o[0], 1'b1);
    chk("full_stb", s_stb_o, 1'b0);
    tick();
    chk("full_bsy_hold", m_bsy_o[0], 1'b1);
    s_ack = 1'b1;
    #1;
    chk("full_bsy_ackcyc", m_bsy_o[0], 1'b1);
    tick();
    s_ack = 1'b0;
    #1;
    chk("full_bsy_free", m_bsy_o[0], 1'b0);
    chk("full_stb16", s_stb_o, 1'b1);
    tick();
    m_stb[0] = 1'b0; s_ack = 1'b1;
    repeat (15) tick();
    s_ack = 1'b0; m_cyc[0] = 1'b0;
    tick();
    chk("full_release", gnt_o, 2'b00);

    // Same-cycle strobe and ack at outstanding 3; ack with nothing outstanding
    do_reset();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    tick();
    repeat (3) tick();
    chk("cnt_three", dut.outst_q, 4'd3);
    s_ack = 1'b1;
    tick();
    chk("cnt_same_cycle", dut.outst_q, 4'd3);
    m_stb[0] = 1'b0;
    repeat (3) tick();
    chk("cnt_drained", dut.outst_q, 4'd0);
    tick();
    chk("cnt_no_underflow", dut.outst_q, 4'd0);
    s_ack = 1'b0; m_cyc[0] = 1'b0;
    tick();
    chk("cnt_release", gnt_o, 2'b00);

    // Reset with two strobes outstanding
    do_reset();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    tick();
    tick();
    tick();
    m_stb[0] = 1'b0;
    chk("rstmid_outst", dut.outst_q, 4'd2);
    rst_n = 1'b0; m_cyc = '0;
    tick();
    s_ack = 1'b1;
    #1;
    chk("rstmid_scyc", s_cyc_o, 1'b0);
    chk("rstmid_gnt", gnt_o, 2'b00);
    chk("rstmid_ack", m_ack_o, 2'b00);
    rst_n = 1'b1;
    s_ack = 1'b0;

`ifdef WBPI_RRARB_TIMEOUT_EN
    // Watchdog abort when the slave never acks
    do_reset();
    m_cyc = 2'b11; m_stb = 2'b01;
    tick();
    m_stb = 2'b00;
    chk("tmo_gnt0", gnt_o, 2'b01);
    n = 0;
    while (!tmo_o && n < 100) begin
      tick();
      n++;
    end
    chk("tmo_cycles", n, 16);
    chk("tmo_pulse", tmo_o, 1'b1);
    chk("tmo_ack", m_ack_o, 2'b01);
    chk("tmo_dat", m_dat_o, 32'hFFFF_FFFF);
    tick();
    chk("tmo_single", tmo_o, 1'b0);
    chk("tmo_idle", gnt_o, 2'b00);
    tick();
    chk("tmo_next_owner", gnt_o, 2'b10);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wbpi_rrarb.md
WBPI_RRARB -- requirements
Module: wbpi_rrarb

Interface
REQ-001 SHALL have parameter MASTERCOUNT, default 2, the number of requesting masters (2..8).
REQ-002 SHALL have parameter ARCHBITSZ, default 32, the data width.
REQ-003 SHALL have parameter ADDRBITSZ, default 30, the word-address width.
REQ-004 SHALL have parameter TIMEOUT, default 1024, the watchdog limit in cycles (used only with WBPI_RRARB_TIMEOUT_EN).
REQ-005 SHALL have ports: clk_2x_w in 1, clock; rst_n in 1, synchronous active-low reset.
REQ-006 SHALL have ports: m_cyc_i, m_stb_i, m_we_i in MASTERCOUNT each, the per-master bus cycle, strobe and write-enable.
REQ-007 SHALL have ports: m_addr_i in MASTERCOUNT*ADDRBITSZ, m_sel_i in MASTERCOUNT*ARCHBITSZ/8 and m_dat_i in MASTERCOUNT*ARCHBITSZ, the flattened per-master request fields.
REQ-008 SHALL have ports: m_bsy_o, m_ack_o out MASTERCOUNT each, and m_dat_o out ARCHBITSZ, shared read data.
REQ-009 SHALL have ports: s_cyc_o, s_stb_o, s_we_o out 1; s_addr_o out ADDRBITSZ; s_sel_o out ARCHBITSZ/8; s_dat_o out ARCHBITSZ.
REQ-010 SHALL have ports: s_bsy_i, s_ack_i in 1; s_dat_i in ARCHBITSZ.
REQ-011 SHALL have port gnt_o out MASTERCOUNT, the one-hot current owner (all-zero when the bus is idle).
REQ-012 SHALL have port tmo_o out 1, a single-cycle watchdog abort pulse.

Function
REQ-013 SHALL implement the states IDLE and OWN, plus ABORT when WBPI_RRARB_TIMEOUT_EN is defined.
REQ-014 In IDLE with any m_cyc_i set, SHALL grant the first requester at or after index rr_ptr (wrapping modulo MASTERCOUNT) and enter OWN on the next edge.
REQ-015 In IDLE, s_cyc_o and s_stb_o SHALL be 0, and all m_bsy_o bits of requesting masters SHALL be 1.
REQ-016 In OWN, the owner's cyc, stb, we, addr, sel and dat SHALL pass combinationally to s_*; the owner's m_bsy_o SHALL equal s_bsy_i, and m_ack_o SHALL equal s_ack_i.
REQ-017 Non-owners SHALL see m_bsy_o = m_cyc_i and m_ack_o = 0.
REQ-018 m_dat_o SHALL equal s_dat_i.
REQ-019 SHALL keep a 4-bit outstanding counter: +1 on an accepted strobe (s_stb_o & !s_bsy_i), -1 on s_ack_i, unchanged when both occur in the same cycle.
REQ-020 When outstanding = 15, SHALL force the owner's m_bsy_o to 1 and s_stb_o to 0.
REQ-021 SHALL return OWN to IDLE only when the owner's m_cyc_i = 0 and outstanding = 0.
REQ-022 On release, rr_ptr SHALL become owner+1 (wrapping MASTERCOUNT-1 to 0); there SHALL be 1 IDLE cycle minimum between owners.
REQ-023 An s_ack_i arriving while outstanding = 0 SHALL be ignored and the counter SHALL NOT underflow.
REQ-024 Grant latency from m_cyc_i rising on an idle bus SHALL be 1 cycle, with the first strobe forwarded in the cycle after the grant edge.

Reset
REQ-025 With rst_n = 0 at a clk_2x_w edge, SHALL set state IDLE, rr_ptr 0, outstanding 0, watchdog 0, gnt_o 0 and tmo_o 0.
REQ-026 A reset mid-transaction SHALL abandon it without issuing an ack, and all s_* outputs SHALL be 0 in the following cycle.

Configuration
REQ-027 When WBPI_RRARB_TIMEOUT_EN is defined, SHALL count OWN cycles without s_ack_i.
REQ-028 When that count reaches TIMEOUT, the block SHALL enter ABORT, pulse tmo_o, assert the owner's m_ack_o for one cycle with m_dat_o = all-ones, clear outstanding, and return to IDLE with rr_ptr advanced.
REQ-029 Without WBPI_RRARB_TIMEOUT_EN, no watchdog logic SHALL exist, tmo_o SHALL be tied to 0, and ABORT SHALL be absent.

Structure
REQ-030 A shared package SHALL hold the state encoding (IDLE=0, OWN=1, ABORT=2), the outstanding width (4) and the outstanding limit (15).
REQ-031 The rotating first-set priority pick SHALL be one sub-module, rr_pick (inputs: request vector and pointer; output: one-hot grant).

Verification
REQ-032 Single master 0: read at addr 0x400 with s_ack_i 2 cycles after the strobe -> gnt_o=01, m_ack_o[0] pulses, m_dat_o=s_dat_i, and the state is IDLE 1 cycle after cyc drops.
REQ-033 Masters 0 and 1 request in the same cycle from reset -> master 0 granted first; after it releases, master 1 is granted; a subsequent tie goes to master 0 again.
REQ-034 Owner issues 16 back-to-back strobes with no ack -> the 16th strobe is held with m_bsy_o=1 until an ack arrives.
REQ-035 Accepted strobe and s_ack_i in the same cycle with outstanding=3 -> outstanding stays 3.
REQ-036 rst_n low while outstanding=2 -> s_cyc_o=0 and gnt_o=0 next cycle, and no m_ack_o is issued.
REQ-037 With WBPI_RRARB_TIMEOUT_EN and TIMEOUT=16, slave never acks -> tmo_o pulses at cycle 16, the owner gets m_ack_o with data 0xFFFFFFFF, and the other master is granted next.
